// File: rtl/ad_trig_capture_if.sv
// Capture-side bus: ADC sample input, arm/abort/trigger controls, RAM write port and capture status.
// ADC_THRESH_TRIG_EN adds the thresh input.
interface ad_trig_capture_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
);
  logic [DATA_W-1:0] ad_data;
  logic              arm;
  logic              abort;
  logic              trig_in;
  logic [3:0]        decim;
`ifdef ADC_THRESH_TRIG_EN
  logic [DATA_W-1:0] thresh;
`endif
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] start_addr;

  modport slave (
    input  ad_data, arm, abort, trig_in, decim,
`ifdef ADC_THRESH_TRIG_EN
    input  thresh,
`endif
    output ram_wr_en, ram_addr, ram_din, busy, done, trig_addr, start_addr
  );

  modport master (
    output ad_data, arm, abort, trig_in, decim,
`ifdef ADC_THRESH_TRIG_EN
    output thresh,
`endif
    input  ram_wr_en, ram_addr, ram_din, busy, done, trig_addr, start_addr
  );
endinterface

// File: rtl/ad_trig_capture.sv
// ADC capture into a circular RAM around a trigger, PRE_N pre-trigger samples, decimated writes.
// A sample is written one cycle after it is registered; ADC_THRESH_TRIG_EN adds a level-crossing trigger.
module ad_trig_capture #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9,
  parameter int PRE_N  = 64
) (
  input  logic               clk_30M,
  input  logic               sys_rst_n,
  output logic               ad_clk,
  ad_trig_capture_if.slave   bus
);
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int POST_N = DEPTH - PRE_N - 1;
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_N - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_N - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_N);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ad_q, ad_d;
  logic              trig_q, trig_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        decim_l_q, decim_l_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic              pend_q, pend_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic strobe, active, arm_ok, wr, trig_edge, thr_evt, evt;

  assign ad_clk    = clk_30M;
  assign strobe    = (cnt_q == 4'd0);
  assign active    = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign arm_ok    = bus.arm && !bus.abort && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign wr        = strobe && active;
  assign trig_edge = bus.trig_in && !trig_q;

`ifdef ADC_THRESH_TRIG_EN
  // Crossing is judged between consecutive written samples, not consecutive ADC samples.
  logic [DATA_W-1:0] last_q, last_d;
  assign thr_evt = wr && (state_q == S_WAIT) && (bus.ad_data >= bus.thresh) && (last_q < bus.thresh);
`else
  assign thr_evt = 1'b0;
`endif

  assign evt = pend_q || trig_edge || thr_evt;

  always_comb begin
    state_d      = state_q;
    ad_d         = bus.ad_data;
    trig_d       = bus.trig_in;
    cnt_d        = strobe ? decim_l_q : cnt_q - 4'd1;
    decim_l_d    = decim_l_q;
    addr_d       = addr_q;
    n_d          = n_q;
    pend_d       = pend_q;
    wr_en_d      = 1'b0;
    ram_addr_d   = ram_addr_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
`ifdef ADC_THRESH_TRIG_EN
    last_d       = last_q;
`endif
    if (bus.abort) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
    end else if (arm_ok) begin
      state_d   = S_PRE;
      cnt_d     = 4'd0;
      decim_l_d = bus.decim;
      addr_d    = '0;
      n_d       = '0;
      pend_d    = 1'b0;
    end else if (wr) begin
      wr_en_d    = 1'b1;
      ram_addr_d = addr_q;
      addr_d     = addr_q + 1'b1;
      n_d        = n_q + 1'b1;
`ifdef ADC_THRESH_TRIG_EN
      last_d     = bus.ad_data;
`endif
      case (state_q)
        S_PRE: begin
          if (n_q == PRE_LAST) begin
            state_d = S_WAIT;
            n_d     = '0;
          end
        end
        S_WAIT: begin
          if (evt) begin
            trig_addr_d  = addr_q;
            start_addr_d = addr_q - PRE_OFS;
            n_d          = '0;
            pend_d       = 1'b0;
            state_d      = (POST_N == 0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (n_q == POST_LAST) state_d = S_DONE;
        end
        default: ;
      endcase
    end else if ((state_q == S_WAIT) && trig_edge) begin
      pend_d = 1'b1;
    end
    busy_d = (state_d == S_PRE) || (state_d == S_WAIT) || (state_d == S_POST);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_30M or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      ad_q         <= '0;
      trig_q       <= 1'b0;
      cnt_q        <= '0;
      decim_l_q    <= '0;
      addr_q       <= '0;
      n_q          <= '0;
      pend_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      ram_addr_q   <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef ADC_THRESH_TRIG_EN
      last_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ad_q         <= ad_d;
      trig_q       <= trig_d;
      cnt_q        <= cnt_d;
      decim_l_q    <= decim_l_d;
      addr_q       <= addr_d;
      n_q          <= n_d;
      pend_q       <= pend_d;
      wr_en_q      <= wr_en_d;
      ram_addr_q   <= ram_addr_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef ADC_THRESH_TRIG_EN
      last_q       <= last_d;
`endif
    end
  end

  assign bus.ram_wr_en  = wr_en_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_din    = ad_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.trig_addr  = trig_addr_q;
  assign bus.start_addr = start_addr_q;
endmodule
